// File: rtl/expression_pipe_pkg.sv
// Shared definitions for the pipelined expression evaluator.
//   op_e       : per-lane opcode encoding
//   OP_W       : opcode field width per lane
//   lane_res_t : one lane's result (sized for the widest legal lane) plus overflow flag
package expression_pipe_pkg;

  localparam int OP_W  = 3;
  localparam int MAX_W = 16;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_XNOR = 3'd2,
    OP_LT   = 3'd3,
    OP_CEQ  = 3'd4,
    OP_SHR  = 3'd5,
    OP_RXOR = 3'd6,
    OP_MUL  = 3'd7
  } op_e;

  typedef struct packed {
    logic [MAX_W-1:0] res;
    logic             ovf;
  } lane_res_t;

endpackage

// File: rtl/expression_alu_lane.sv
// Combinational ALU for one lane.
//   op  : opcode (op_e encoding)
//   a,b : operands, W bits, signed or unsigned per SIGNED
//   res : result truncated to W bits (1-bit results zero-extended)
//   ovf : overflow for ADD/SUB/MUL, 0 otherwise
module expression_alu_lane
  import expression_pipe_pkg::*;
#(
  parameter int   W      = 6,
  parameter logic SIGNED = 1'b0
) (
  input  logic [OP_W-1:0] op,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  output logic [W-1:0]    res,
  output logic            ovf
);

  logic [W:0]     ax, bx, sum, diff;
  logic [2*W-1:0] pa, pb, prod;
  logic [W:0]     prod_hi;
  logic [W-1:0]   shr_s, shr_u;
  logic           lt, add_ovf, sub_ovf, mul_ovf;

  // One guard bit for add/sub, full double width for the product; both
  // extended according to lane signedness so the true result is exact.
  assign ax = {SIGNED & a[W-1], a};
  assign bx = {SIGNED & b[W-1], b};
  assign pa = {{W{SIGNED & a[W-1]}}, a};
  assign pb = {{W{SIGNED & b[W-1]}}, b};

  assign sum     = ax + bx;
  assign diff    = ax - bx;
  assign prod    = pa * pb;
  assign prod_hi = prod[2*W-1:W-1];

  assign add_ovf = SIGNED ? (sum[W] ^ sum[W-1])   : sum[W];
  assign sub_ovf = SIGNED ? (diff[W] ^ diff[W-1]) : diff[W];
  // Signed product fits iff the top W+1 bits are all copies of the sign.
  assign mul_ovf = SIGNED ? !((&prod_hi) || !(|prod_hi)) : (|prod[2*W-1:W]);

  assign shr_s = $signed(a) >>> b[2:0];
  assign shr_u = a >> b[2:0];
  assign lt    = SIGNED ? ($signed(a) < $signed(b)) : (a < b);

  always_comb begin
    res = '0;
    ovf = 1'b0;
    case (op_e'(op))
      OP_ADD:  begin res = sum[W-1:0];  ovf = add_ovf; end
      OP_SUB:  begin res = diff[W-1:0]; ovf = sub_ovf; end
      OP_XNOR: res = a ^ ~b;
      OP_LT:   res[0] = lt;
      OP_CEQ:  res[0] = (a == b);
      OP_SHR:  res = SIGNED ? shr_s : shr_u;
      OP_RXOR: res[0] = ^a;
      OP_MUL:  begin res = prod[W-1:0]; ovf = mul_ovf; end
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/expression_pipe_eval.sv
// NCH-lane expression evaluator with a STAGES-deep valid/ready pipeline.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : input beat handshake
//   op, a, b            : packed per-lane opcode and operands
//   out_valid/out_ready : result beat handshake
//   y, ovf              : packed per-lane results and overflow flags
//   res_cnt             : wrapping count of delivered results
module expression_pipe_eval
  import expression_pipe_pkg::*;
#(
  parameter int               NCH         = 6,
  parameter int               W           = 6,
  parameter int               STAGES      = 2,
  parameter logic [NCH-1:0]   SIGNED_MASK = 6'b111000,
  parameter int               CNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OP_W*NCH-1:0] op,
  input  logic [W*NCH-1:0]    a,
  input  logic [W*NCH-1:0]    b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [W*NCH-1:0]    y,
  output logic [NCH-1:0]      ovf,
  output logic [CNT_W-1:0]    res_cnt
);

  logic [W*NCH-1:0] alu_y;
  logic [NCH-1:0]   alu_ovf;

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    expression_alu_lane #(
      .W      (W),
      .SIGNED (SIGNED_MASK[i])
    ) u_lane (
      .op  (op[OP_W*i +: OP_W]),
      .a   (a[W*i +: W]),
      .b   (b[W*i +: W]),
      .res (alu_y[W*i +: W]),
      .ovf (alu_ovf[i])
    );
  end

  logic [STAGES-1:0] stg_valid, stg_load, src_valid;
  logic [W*NCH-1:0]  stg_y   [STAGES];
  logic [NCH-1:0]    stg_ovf [STAGES];
  logic [W*NCH-1:0]  src_y   [STAGES];
  logic [NCH-1:0]    src_ovf [STAGES];

  // "Empty or downstream loading" unrolled: stage k can load when the
  // consumer is ready or any stage from k to the output has a hole.
  for (genvar k = 0; k < STAGES; k++) begin : g_load
    assign stg_load[k] = out_ready || !(&stg_valid[STAGES-1:k]);
  end

  always_comb begin
    src_valid[0] = in_valid;
    src_y[0]     = alu_y;
    src_ovf[0]   = alu_ovf;
    for (int unsigned k = 1; k < STAGES; k++) begin
      src_valid[k] = stg_valid[k-1];
      src_y[k]     = stg_y[k-1];
      src_ovf[k]   = stg_ovf[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_valid <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        stg_y[k]   <= '0;
        stg_ovf[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (stg_load[k]) begin
          stg_valid[k] <= src_valid[k];
          // Bubbles only clear the valid bit; data keeps its last value.
          if (src_valid[k]) begin
            stg_y[k]   <= src_y[k];
            stg_ovf[k] <= src_ovf[k];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_cnt <= '0;
    end else if (out_valid && out_ready) begin
      res_cnt <= res_cnt + 1'b1;
    end
  end

  assign in_ready  = stg_load[0];
  assign out_valid = stg_valid[STAGES-1];
  assign y         = stg_y[STAGES-1];
  assign ovf       = stg_ovf[STAGES-1];

endmodule

// File: tb/tb_expression_pipe_eval.sv
module tb_expression_pipe_eval;

  localparam int NCH    = 6;
  localparam int W      = 6;
  localparam int STAGES = 2;
  localparam int CNT_W  = 8;
  localparam logic [NCH-1:0] SMASK = 6'b111000;
  localparam int OPV = 3 * NCH;
  localparam int AW  = W * NCH;
  localparam int NVEC = 12;

  logic           clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [OPV-1:0] op;
  logic [AW-1:0]  a, b, y;
  logic [NCH-1:0] ovf;
  logic [CNT_W-1:0] res_cnt;

  expression_pipe_eval #(
    .NCH         (NCH),
    .W           (W),
    .STAGES      (STAGES),
    .SIGNED_MASK (SMASK),
    .CNT_W       (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .ovf       (ovf),
    .res_cnt   (res_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0]  y;
    logic [NCH-1:0] ovf;
  } exp_t;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a, b, yu, ys;
    logic         ou, os;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  exp_t sb_q[$];
  logic [CNT_W-1:0] exp_cnt = '0;
  logic stall_prev = 1'b0;
  logic [AW+NCH-1:0] held;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Independent integer reference model.
  function automatic exp_t model(input logic [OPV-1:0] o, input logic [AW-1:0] av, input logic [AW-1:0] bv);
    exp_t e;
    int half, maxu;
    half = 1 << (W - 1);
    maxu = (1 << W) - 1;
    e = '0;
    for (int i = 0; i < NCH; i++) begin
      int ua, ub, sa, sb, va, vb, t, r, sh;
      logic ov;
      logic sg;
      sg = SMASK[i];
      ua = int'(av[W*i +: W]);
      ub = int'(bv[W*i +: W]);
      sa = (ua >= half) ? ua - (1 << W) : ua;
      sb = (ub >= half) ? ub - (1 << W) : ub;
      va = sg ? sa : ua;
      vb = sg ? sb : ub;
      ov = 1'b0;
      r  = 0;
      case (o[3*i +: 3])
        3'd0: begin t = va + vb; r = t; ov = sg ? (t < -half || t > half - 1) : (t > maxu); end
        3'd1: begin t = va - vb; r = t; ov = sg ? (t < -half || t > half - 1) : (t < 0); end
        3'd2: r = ~(ua ^ ub);
        3'd3: r = (va < vb) ? 1 : 0;
        3'd4: r = (ua == ub) ? 1 : 0;
        3'd5: begin sh = ub & 7; r = sg ? (sa >>> sh) : (ua >> sh); end
        3'd6: r = {31'd0, ^av[W*i +: W]};
        default: begin t = va * vb; r = t; ov = sg ? (t < -half || t > half - 1) : (t > maxu); end
      endcase
      e.y[W*i +: W] = r[W-1:0];
      e.ovf[i] = ov;
    end
    return e;
  endfunction

  // Scoreboard monitor: handshakes sampled at negedge describe the next posedge.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_q.delete();
      exp_cnt    = '0;
      stall_prev = 1'b0;
    end else begin
      exp_t e;
      check("res_cnt", 64'(res_cnt), 64'(exp_cnt));
      if (stall_prev) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_hold", 64'({y, ovf}), 64'(held));
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got y=%0h with no beat outstanding", y);
        end else begin
          e = sb_q.pop_front();
          check("sb_y", 64'(y), 64'(e.y));
          check("sb_ovf", 64'(ovf), 64'(e.ovf));
        end
        exp_cnt = exp_cnt + 1'b1;
      end
      if (in_valid && in_ready) begin
        sb_q.push_back(model(op, a, b));
        n_acc++;
      end
      stall_prev = out_valid && !out_ready;
      held       = {y, ovf};
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [OPV-1:0] o, input logic [AW-1:0] aa, input logic [AW-1:0] bb);
    int n;
    n = 0;
    in_valid = 1'b1;
    op = o;
    a  = aa;
    b  = bb;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("drain_empty", 64'(sb_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  vec_t vecs [NVEC];

  initial begin
    logic [AW-1:0] ey;
    logic [NCH-1:0] eo;
    logic [AW+NCH-1:0] hold_v;
    int acc0, n, cyc;

    vecs[0]  = '{3'd0, 6'h1F, 6'h01, 6'h20, 6'h20, 1'b0, 1'b1};
    vecs[1]  = '{3'd0, 6'h3F, 6'h01, 6'h00, 6'h00, 1'b1, 1'b0};
    vecs[2]  = '{3'd1, 6'h00, 6'h01, 6'h3F, 6'h3F, 1'b1, 1'b0};
    vecs[3]  = '{3'd1, 6'h20, 6'h01, 6'h1F, 6'h1F, 1'b0, 1'b1};
    vecs[4]  = '{3'd7, 6'h08, 6'h08, 6'h00, 6'h00, 1'b1, 1'b1};
    vecs[5]  = '{3'd7, 6'h3F, 6'h3F, 6'h01, 6'h01, 1'b1, 1'b0};
    vecs[6]  = '{3'd2, 6'h2A, 6'h15, 6'h00, 6'h00, 1'b0, 1'b0};
    vecs[7]  = '{3'd3, 6'h3F, 6'h01, 6'h00, 6'h01, 1'b0, 1'b0};
    vecs[8]  = '{3'd4, 6'h2A, 6'h2A, 6'h01, 6'h01, 1'b0, 1'b0};
    vecs[9]  = '{3'd5, 6'h20, 6'h02, 6'h08, 6'h38, 1'b0, 1'b0};
    vecs[10] = '{3'd5, 6'h20, 6'h07, 6'h00, 6'h3F, 1'b0, 1'b0};
    vecs[11] = '{3'd6, 6'h07, 6'h00, 6'h01, 6'h01, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0;
    #3;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_y", 64'(y), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_res_cnt", 64'(res_cnt), 64'd0);
    #20;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed table, one beat at a time.
    for (int v = 0; v < NVEC; v++) begin
      for (int i = 0; i < NCH; i++) begin
        ey[W*i +: W] = SMASK[i] ? vecs[v].ys : vecs[v].yu;
        eo[i]        = SMASK[i] ? vecs[v].os : vecs[v].ou;
      end
      send({NCH{vecs[v].op}}, {NCH{vecs[v].a}}, {NCH{vecs[v].b}});
      n = 0;
      while (!out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("tbl_valid", 64'(out_valid), 64'd1);
      check($sformatf("tbl%0d_y", v), 64'(y), 64'(ey));
      check($sformatf("tbl%0d_ovf", v), 64'(ovf), 64'(eo));
      @(posedge clk);
      #1;
    end
    drain();

    // Backpressure: only STAGES beats fit while the consumer stalls.
    out_ready = 1'b0;
    acc0 = n_acc;
    fork
      begin
        for (int k = 0; k < 4; k++)
          send({NCH{3'd0}}, {NCH{6'(k + 1)}}, {NCH{6'(k * 5)}});
      end
      begin
        n = 0;
        while (n_acc < acc0 + STAGES && n < 50) begin
          @(negedge clk);
          #1;
          n++;
        end
        @(negedge clk);
        #1;
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        check("bp_accepted", 64'(n_acc - acc0), 64'(STAGES));
        hold_v = {y, ovf};
        repeat (4) begin
          @(negedge clk);
          #1;
          check("bp_y_stable", 64'({y, ovf}), 64'(hold_v));
          check("bp_still_blocked", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_res_cnt", 64'(res_cnt), 64'(NVEC + 4));

    // Reset with two beats in flight.
    send({NCH{3'd7}}, {NCH{6'h05}}, {NCH{6'h03}});
    send({NCH{3'd1}}, {NCH{6'h09}}, {NCH{6'h02}});
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_y", 64'(y), 64'd0);
    check("mid_rst_res_cnt", 64'(res_cnt), 64'd0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (5) begin
      @(negedge clk);
      check("no_stale_beat", 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1;

    // 256 deliveries wrap the counter.
    for (int k = 0; k < 256; k++)
      send(OPV'($urandom), AW'({$urandom, $urandom}), AW'({$urandom, $urandom}));
    drain();
    check("cnt_wrap", 64'(res_cnt), 64'd0);

    // Random traffic against the scoreboard.
    acc0 = n_acc;
    cyc  = 0;
    while (n_acc - acc0 < 10000 && cyc < 60000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      op        = OPV'($urandom);
      a         = AW'({$urandom, $urandom});
      b         = AW'({$urandom, $urandom});
      out_ready = ($urandom_range(0, 9) < 7);
      @(posedge clk);
      #1;
      cyc++;
    end
    check("rand_beats", 64'(n_acc - acc0 >= 10000), 64'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
